// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and defaults for the CPU run controller
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CPU_RST = 2'd0,
    ST_HALT    = 2'd1,
    ST_RUN     = 2'd2,
    ST_STEP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP       = 2'd0,
    CMD_RUN       = 2'd1,
    CMD_STEP      = 2'd2,
    CMD_RESET_CPU = 2'd3
  } cmd_e;

  localparam int DEF_PC_W         = 8;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_STEP_TIMEOUT = 15;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/halt/single-step sequencer with PC breakpoint
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             break_en,
  input  logic [PC_W-1:0]  break_addr,
  input  logic [PC_W-1:0]  cpu_pc,
  input  logic             cpu_retire,
  output logic             cpu_en,
  output logic             cpu_reset,
  output logic             halted,
  output logic             break_hit,
  output logic             step_timeout,
  output logic [CNT_W-1:0] retire_count,
  output logic [1:0]       state_o
);

  // One down-counter serves both reset hold and step timeout; the states never overlap.
  localparam int DC_W = $clog2(max_int(RST_CYCLES, STEP_TIMEOUT) + 1);
  localparam logic [DC_W-1:0] RST_LOAD  = DC_W'(RST_CYCLES - 1);
  localparam logic [DC_W-1:0] STEP_LOAD = DC_W'(STEP_TIMEOUT);

  state_e          state, state_nx;
  logic [DC_W-1:0] dcnt, dcnt_nx, dcnt_dec;
  logic            break_hit_nx, step_timeout_nx;
  logic            cnt_clr, accept, bp_match;

  assign accept   = cmd_valid && cmd_ready;
  assign bp_match = break_en && cpu_retire && (cpu_pc == break_addr);
  assign dcnt_dec = dcnt - 1'b1;

  assign cpu_en    = (state == ST_RUN) || (state == ST_STEP);
  assign cpu_reset = (state == ST_CPU_RST);
  assign halted    = (state == ST_HALT);
  assign cmd_ready = (state == ST_HALT) || (state == ST_RUN);
  assign state_o   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_CPU_RST;
      dcnt         <= RST_LOAD;
      break_hit    <= 1'b0;
      step_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      dcnt         <= dcnt_nx;
      break_hit    <= break_hit_nx;
      step_timeout <= step_timeout_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    dcnt_nx         = dcnt;
    break_hit_nx    = break_hit;
    step_timeout_nx = step_timeout;
    cnt_clr         = 1'b0;
    case (state)
      ST_CPU_RST: begin
        if (dcnt == '0) state_nx = ST_HALT;
        else            dcnt_nx  = dcnt_dec;
      end
      ST_HALT: begin
        if (accept) begin
          case (cmd)
            CMD_RUN: begin
              state_nx     = ST_RUN;
              break_hit_nx = 1'b0;
            end
            CMD_STEP: begin
              state_nx        = ST_STEP;
              dcnt_nx         = STEP_LOAD;
              step_timeout_nx = 1'b0;
              break_hit_nx    = 1'b0;
            end
            CMD_RESET_CPU: begin
              state_nx        = ST_CPU_RST;
              dcnt_nx         = RST_LOAD;
              break_hit_nx    = 1'b0;
              step_timeout_nx = 1'b0;
              cnt_clr         = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // A host reset outranks a breakpoint landing in the same cycle.
        if (accept && (cmd == CMD_RESET_CPU)) begin
          state_nx        = ST_CPU_RST;
          dcnt_nx         = RST_LOAD;
          break_hit_nx    = 1'b0;
          step_timeout_nx = 1'b0;
          cnt_clr         = 1'b1;
        end else if (bp_match) begin
          state_nx     = ST_HALT;
          break_hit_nx = 1'b1;
        end else if (accept && (cmd == CMD_STEP)) begin
          state_nx = ST_HALT;
        end
      end
      ST_STEP: begin
        if (cpu_retire) begin
          state_nx = ST_HALT;
          if (bp_match) break_hit_nx = 1'b1;
        end else begin
          dcnt_nx = dcnt_dec;
          if (dcnt_dec == '0) begin
            state_nx        = ST_HALT;
            step_timeout_nx = 1'b1;
          end
        end
      end
      default: state_nx = ST_CPU_RST;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cpu_retire && cpu_en),
    .count (retire_count)
  );

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for cpu_run_controller
module tb_cpu_run_controller;

  localparam int PC_W         = 8;
  localparam int CNT_W        = 4;
  localparam int RST_CYCLES   = 4;
  localparam int STEP_TIMEOUT = 15;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
  localparam bit [1:0] C_NOP = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_RST = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'd0;
  logic             cmd_ready;
  logic             break_en = 1'b0;
  logic [PC_W-1:0]  break_addr = '0;
  logic [PC_W-1:0]  cpu_pc = '0;
  logic             cpu_retire = 1'b0;
  logic             cpu_en, cpu_reset, halted, break_hit, step_timeout;
  logic [CNT_W-1:0] retire_count;
  logic [1:0]       state_o;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .STEP_TIMEOUT(STEP_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .break_en(break_en), .break_addr(break_addr), .cpu_pc(cpu_pc), .cpu_retire(cpu_retire),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset), .halted(halted), .break_hit(break_hit),
    .step_timeout(step_timeout), .retire_count(retire_count), .state_o(state_o)
  );

  typedef struct packed {
    logic             cpu_en;
    logic             cpu_reset;
    logic             halted;
    logic             cmd_ready;
    logic             break_hit;
    logic             step_timeout;
    logic [CNT_W-1:0] retire_count;
    logic [1:0]       state_o;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: mode uses the documented state_o numbering; timers count cycles left.
  int m_mode, m_rst_left, m_step_left, m_cnt;
  bit m_bh, m_st;

  function void m_enter_rst();
    m_mode = 0; m_rst_left = RST_CYCLES; m_bh = 0; m_st = 0; m_cnt = 0;
  endfunction

  function void m_step();
    bit en, acc, bp;
    if (!rst_n) begin
      m_enter_rst();
      return;
    end
    en  = (m_mode == 2) || (m_mode == 3);
    acc = cmd_valid && ((m_mode == 1) || (m_mode == 2));
    bp  = break_en && cpu_retire && (cpu_pc == break_addr);
    if (en && cpu_retire && m_cnt < CNT_MAX) m_cnt++;
    case (m_mode)
      0: begin
        m_rst_left--;
        if (m_rst_left == 0) m_mode = 1;
      end
      1: if (acc) begin
        if (cmd == C_RUN) begin m_mode = 2; m_bh = 0; end
        else if (cmd == C_STEP) begin m_mode = 3; m_step_left = STEP_TIMEOUT; m_st = 0; m_bh = 0; end
        else if (cmd == C_RST) m_enter_rst();
      end
      2: begin
        if (acc && cmd == C_RST) m_enter_rst();
        else if (bp) begin m_mode = 1; m_bh = 1; end
        else if (acc && cmd == C_STEP) m_mode = 1;
      end
      default: begin
        if (cpu_retire) begin
          m_mode = 1;
          if (bp) m_bh = 1;
        end else begin
          m_step_left--;
          if (m_step_left == 0) begin m_mode = 1; m_st = 1; end
        end
      end
    endcase
  endfunction

  function obs_t m_obs();
    obs_t o;
    o.cpu_en       = (m_mode >= 2);
    o.cpu_reset    = (m_mode == 0);
    o.halted       = (m_mode == 1);
    o.cmd_ready    = (m_mode == 1) || (m_mode == 2);
    o.break_hit    = m_bh;
    o.step_timeout = m_st;
    o.retire_count = CNT_W'(m_cnt);
    o.state_o      = 2'(m_mode);
    return o;
  endfunction

  // Monitor: every cycle the DUT presents a full output set, compared at the falling edge.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.cpu_en = cpu_en; a.cpu_reset = cpu_reset; a.halted = halted; a.cmd_ready = cmd_ready;
      a.break_hit = break_hit; a.step_timeout = step_timeout;
      a.retire_count = retire_count; a.state_o = state_o;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs at %0t got=%h exp=%h", $time, a, e);
      end
    end
  end

  task automatic drive(input bit v, input bit [1:0] c, input bit r, input bit [PC_W-1:0] pc,
                       input bit rn);
    @(posedge clk);
    m_step();
    #1;
    cmd_valid = v; cmd = c; cpu_retire = r; cpu_pc = pc; rst_n = rn;
    if (!rn) m_enter_rst();
    exp_q.push_back(m_obs());
  endtask

  task automatic idle();
    drive(0, C_NOP, 0, '0, 1);
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  initial begin
    int rp;
    m_enter_rst();
    break_en = 1'b1; break_addr = 8'h10;
    repeat (3) drive(0, C_NOP, 0, '0, 0);
    drive(1, C_RUN, 0, '0, 1);
    repeat (3) idle();
    expect_val("rst_hold", cpu_reset, 1);
    idle();
    expect_val("rst_release_state", state_o, 1);
    expect_val("rst_release_en", cpu_en, 0);
    expect_val("rst_release_cnt", retire_count, 0);

    drive(1, C_RUN, 0, '0, 1);
    drive(0, C_NOP, 1, 8'h0C, 1); idle();
    drive(0, C_NOP, 1, 8'h0E, 1); idle();
    drive(0, C_NOP, 1, 8'h10, 1); idle();
    expect_val("bp_state", state_o, 1);
    expect_val("bp_hit", break_hit, 1);
    expect_val("bp_cnt", retire_count, 3);

    drive(1, C_STEP, 0, '0, 1); idle(); idle();
    drive(0, C_NOP, 1, 8'h20, 1); idle();
    expect_val("step_cnt", retire_count, 4);
    expect_val("step_to_flag", step_timeout, 0);
    expect_val("step_hit_clr", break_hit, 0);

    drive(1, C_STEP, 0, '0, 1);
    repeat (15) idle();
    expect_val("step_to_last_en", cpu_en, 1);
    idle();
    expect_val("step_to_state", state_o, 1);
    expect_val("step_to_set", step_timeout, 1);
    expect_val("step_to_cnt", retire_count, 4);

    drive(1, C_RUN, 0, '0, 1); idle();
    drive(1, C_RST, 1, 8'h10, 1); idle();
    expect_val("sim1_state", state_o, 0);
    expect_val("sim1_hit", break_hit, 0);
    expect_val("sim1_cnt", retire_count, 0);
    repeat (4) idle();

    drive(1, C_RUN, 0, '0, 1); idle();
    drive(1, C_STEP, 1, 8'h10, 1); idle();
    expect_val("sim2_state", state_o, 1);
    expect_val("sim2_hit", break_hit, 1);

    drive(1, C_RUN, 0, '0, 1);
    repeat (20) drive(0, C_NOP, 1, 8'h40, 1);
    idle();
    expect_val("sat_cnt", retire_count, CNT_MAX);
    drive(1, C_RST, 0, '0, 1);
    repeat (4) drive(1, C_RUN, 0, '0, 1);
    idle();
    expect_val("ignored_cmd_state", state_o, 1);

    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 2))
        0: rp = 0;
        1: rp = 10;
        default: rp = 40;
      endcase
      break_en   = 1'($urandom_range(0, 1));
      break_addr = PC_W'($urandom_range(0, 255));
      for (int i = 0; i < 40; i++) begin
        drive(($urandom % 100) < 40, 2'($urandom_range(0, 3)), ($urandom % 100) < rp,
              ($urandom % 2) ? break_addr : PC_W'($urandom_range(0, 255)),
              ($urandom % 100) != 0);
      end
    end
    idle();

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Run/halt/single-step sequencer for CPUCore; sits between the top-level pin wrapper and the core.
- Gates the core through a clock-enable (cpu_en) and drives a synchronous core reset (cpu_reset).
- Accepts commands from a host (switch/uio decode) and halts on a PC breakpoint.
- Keeps a saturating retired-instruction counter for debug readout on output pins.

Parameters:
- PC_W, 8, width of CPU program counter and breakpoint address
- CNT_W, 16, width of retired-instruction counter
- RST_CYCLES, 4, cycles cpu_reset is held in CPU_RST (>=1)
- STEP_TIMEOUT, 15, max cycles STEP waits for a retire before aborting (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command strobe
- cmd  in  2  0=NOP, 1=RUN, 2=STEP, 3=RESET_CPU
- cmd_ready  out  1  controller can accept cmd this cycle
- break_en  in  1  breakpoint enable
- break_addr  in  PC_W  breakpoint PC
- cpu_pc  in  PC_W  core PC after the current retire (valid when cpu_retire=1)
- cpu_retire  in  1  one-cycle pulse per retired instruction
- cpu_en  out  1  core clock-enable
- cpu_reset  out  1  synchronous reset to core, active high
- halted  out  1  state==HALT
- break_hit  out  1  sticky: halted by breakpoint
- step_timeout  out  1  sticky: last STEP aborted
- retire_count  out  CNT_W  saturating retire counter
- state_o  out  2  0=CPU_RST, 1=HALT, 2=RUN, 3=STEP

Behaviour:
- Async reset (rst_n=0):
  - state=CPU_RST, rst counter=RST_CYCLES-1, retire_count=0, break_hit=0, step_timeout=0.
  - Outputs: cpu_reset=1, cpu_en=0, halted=0, cmd_ready=0.
- Outputs decode combinationally from registered state:
  - cpu_en=1 only in RUN and STEP.
  - cpu_reset=1 only in CPU_RST.
  - cmd_ready=1 in HALT and RUN.
- Command handshake:
  - A command is accepted when cmd_valid and cmd_ready are both 1.
  - cmd is ignored when cmd_ready=0; it is not queued.
  - NOP is accepted with no effect.
- CPU_RST:
  - Count down each cycle.
  - At 0, go to HALT. cpu_reset is high exactly RST_CYCLES cycles.
- HALT:
  - RUN -> RUN.
  - STEP -> STEP; load timeout counter with STEP_TIMEOUT; clear step_timeout.
  - RESET_CPU -> CPU_RST; clear break_hit, step_timeout, retire_count.
  - Accepting RUN or STEP clears break_hit.
- RUN:
  - Priority, highest first:
    1. Accepted RESET_CPU -> CPU_RST.
    2. Breakpoint (break_en && cpu_retire && cpu_pc==break_addr) -> HALT, set break_hit.
    3. Accepted STEP -> HALT. STEP acts as a halt request while running.
    4. Otherwise stay in RUN.
  - RUN received while in RUN: stay in RUN.
- STEP:
  - On cpu_retire -> HALT.
  - Breakpoint match on that retire also sets break_hit.
  - Otherwise decrement the timeout counter; at 0 with no retire -> HALT and set step_timeout.
  - The core therefore sees cpu_en for at most STEP_TIMEOUT cycles.
- Counter and enable timing:
  - retire_count increments on each cycle with cpu_retire=1 and cpu_en=1, including the retire that causes a halt.
  - retire_count saturates at all-ones, with no wrap.
  - cpu_retire while cpu_en=0 is ignored.
  - Latency: cpu_en changes in the cycle after the accepting or triggering edge.
- Mid-operation rst_n assertion aborts any state immediately to the reset values.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum (CPU_RST, HALT, RUN, STEP) with the encoding above;
  - cmd enum (NOP, RUN, STEP, RESET_CPU);
  - default width constants.
- No sub-module is required. The FSM, rst/timeout down-counter (shared, since the states are exclusive) and saturating counter fit one module.
- An optional sat_counter sub-module may be instantiated for retire_count.

Test Plan:
- Reset and release:
  - Stimulus: rst_n low 3 cycles, then high.
  - Required: cpu_reset=1 for exactly 4 cycles, then state_o=1, halted=1, cpu_en=0, retire_count=0.
- Run to breakpoint:
  - Stimulus: break_en=1, break_addr=0x10; RUN; retire pulses with cpu_pc 0x0C,0x0E,0x10.
  - Required: HALT the cycle after the 0x10 retire, break_hit=1, retire_count=3, cpu_en=0.
- Single step:
  - Stimulus: from HALT, STEP; cpu_retire after 2 cycles.
  - Required: cpu_en high 3 cycles, then HALT, retire_count+1, step_timeout=0.
- Step timeout:
  - Stimulus: STEP with no retire.
  - Required: HALT after exactly 15 enabled cycles, step_timeout=1, retire_count unchanged.
- Simultaneous events:
  - Stimulus 1: in RUN, breakpoint retire and accepted RESET_CPU in the same cycle.
  - Required 1: CPU_RST, break_hit=0, retire_count=0.
  - Stimulus 2: breakpoint plus STEP in the same cycle.
  - Required 2: HALT, break_hit=1.
- Saturation and ignored commands:
  - Stimulus: with CNT_W=4, 20 retires in RUN; also cmd_valid during CPU_RST.
  - Required: retire_count stays at 15; the command during CPU_RST has no effect.
